noc_input_port_ctrl: RTL and testbench

- Per-direction input port controller for the 5-port (N/S/W/E/L) YX-routed NoC router. One instance per input direction.
- Buffers incoming flits and extracts the destination address from each header flit.
- Drives the arbiter's header-address and next-hop-write inputs, requests and waits for an output grant, then forwards the packet to the crossbar.
- Pulses a release when the tail flit leaves; this pulse drives the round-robin change-order input of the granted output port.

---
 rtl/noc_input_port_ctrl.sv | 133 +++++++++++++
 tb/tb_noc_input_port_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_input_port_ctrl.sv
// Input port controller for the YX-routed 5-port NoC router.
// Buffers flits, drives the route/arbitration handshake and forwards packets.
module noc_input_port_ctrl #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] flit_i,
    input  logic              flit_valid_i,
    output logic              flit_ready_o,
    output logic [7:0]        ipc_addr_header_o,
    output logic              ipc_nhr_write_o,
    output logic              ipc_request_o,
    input  logic              ipc_grant_i,
    output logic [DATA_W-1:0] flit_o,
    output logic              flit_valid_o,
    input  logic              flit_ready_i,
    output logic              ipc_release_o,
    output logic              ipc_err_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        WAIT_GRANT,
        FORWARD
    } state_t;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q, count_d;
    state_t            state_q, state_d;
    logic [7:0]        addr_q, addr_d;
    logic              first_q, first_d;
    logic              rel_q, rel_d;
    logic              err_q, err_d;

    logic              empty, full, push, pop, xfer, discard;
    logic [DATA_W-1:0] head;
    logic              is_head, is_tail;

    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign head    = mem_q[rd_ptr_q];
    // Type bit [W-2] marks a header, bit [W-1] marks a tail; 2'b11 is both.
    assign is_head = head[DATA_W-2];
    assign is_tail = head[DATA_W-1];

    assign flit_ready_o      = !full && !reset;
    assign push              = flit_valid_i && flit_ready_o;
    assign flit_o            = head;
    assign flit_valid_o      = (state_q == FORWARD) && !empty && ipc_grant_i;
    assign xfer              = flit_valid_o && flit_ready_i;
    assign pop               = xfer || discard;
    assign ipc_addr_header_o = addr_q;
    assign ipc_nhr_write_o   = (state_q == ROUTE);
    assign ipc_request_o     = (state_q == WAIT_GRANT);
    assign ipc_release_o     = rel_q;
    assign ipc_err_o         = err_q;

    assign count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        first_d = first_q;
        rel_d   = 1'b0;
        err_d   = err_q;
        discard = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    if (is_head) begin
                        addr_d  = head[7:0];
                        state_d = ROUTE;
                    end else begin
                        discard = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            ROUTE: state_d = WAIT_GRANT;
            WAIT_GRANT: begin
                if (ipc_grant_i) begin
                    state_d = FORWARD;
                    first_d = 1'b1;
                end
            end
            FORWARD: begin
                if (xfer) begin
                    first_d = 1'b0;
                    if (is_head && !first_q) err_d = 1'b1;
                    if (is_tail) begin
                        state_d = IDLE;
                        rel_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            addr_q   <= '0;
            first_q  <= 1'b0;
            rel_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            state_q <= state_d;
            addr_q  <= addr_d;
            first_q <= first_d;
            rel_q   <= rel_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_noc_input_port_ctrl.sv
// Scoreboard bench for noc_input_port_ctrl: packet-level stream model,
// directed latency/fill/error/reset cases plus randomized traffic.
module tb_noc_input_port_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] flit_i = '0;
    logic        flit_valid_i = 1'b0;
    logic        flit_ready_o;
    logic [7:0]  ipc_addr_header_o;
    logic        ipc_nhr_write_o;
    logic        ipc_request_o;
    logic        ipc_grant_i = 1'b0;
    logic [31:0] flit_o;
    logic        flit_valid_o;
    logic        flit_ready_i = 1'b0;
    logic        ipc_release_o;
    logic        ipc_err_o;

    noc_input_port_ctrl #(.DATA_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .flit_i(flit_i), .flit_valid_i(flit_valid_i),
        .flit_ready_o(flit_ready_o),
        .ipc_addr_header_o(ipc_addr_header_o),
        .ipc_nhr_write_o(ipc_nhr_write_o),
        .ipc_request_o(ipc_request_o), .ipc_grant_i(ipc_grant_i),
        .flit_o(flit_o), .flit_valid_o(flit_valid_o),
        .flit_ready_i(flit_ready_i),
        .ipc_release_o(ipc_release_o), .ipc_err_o(ipc_err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q[$];
    logic [7:0]  addr_exp_q[$];
    bit          in_pkt = 0;
    bit          err_exp = 0;
    bit          rel_exp = 0;
    int          pkts_exp = 0;
    int          rel_seen = 0;
    int          last_rel_cyc = -100;
    int          last_gap = 0;
    bit          rnd_mode = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic fail(string name);
        checks++;
        errors++;
        $display("FAIL %s t=%0t", name, $time);
    endtask

    // Packet-stream view: a header opens a packet, a tail closes it,
    // anything arriving outside a packet is dropped and flags an error.
    function automatic void model_accept(logic [31:0] f);
        bit hd = f[30];
        bit tl = f[31];
        if (!in_pkt) begin
            if (hd) begin
                exp_q.push_back(f);
                addr_exp_q.push_back(f[7:0]);
                if (tl) pkts_exp++;
                else in_pkt = 1;
            end else begin
                err_exp = 1;
            end
        end else begin
            exp_q.push_back(f);
            if (hd) err_exp = 1;
            if (tl) begin
                in_pkt = 0;
                pkts_exp++;
            end
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        bit rel_n;
        logic [31:0] e;
        rel_n = 0;
        if (!reset) begin
            if (flit_valid_o) chk("valid_needs_grant", 32'(ipc_grant_i), 32'd1);
            if (ipc_release_o || rel_exp)
                chk("release", 32'(ipc_release_o), 32'(rel_exp));
            if (ipc_release_o) begin
                rel_seen++;
                last_rel_cyc = cyc;
            end
            if (flit_valid_o && flit_ready_i) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_flit");
                end else begin
                    e = exp_q.pop_front();
                    chk("flit_o", flit_o, e);
                    rel_n = e[31];
                end
            end
            if (ipc_nhr_write_o) begin
                last_gap = cyc - last_rel_cyc;
                if (addr_exp_q.size() == 0) fail("unexpected_nhr_write");
                else chk("addr_header", 32'(ipc_addr_header_o),
                         32'(addr_exp_q.pop_front()));
            end
            if (flit_valid_i && flit_ready_o) model_accept(flit_i);
        end
        rel_exp = rel_n;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_mode) begin
                ipc_grant_i  = ($urandom_range(0, 3) != 0);
                flit_ready_i = ($urandom_range(0, 2) != 0);
            end
        end
    end

    task automatic send(logic [31:0] f);
        int n = 0;
        flit_i = f;
        flit_valid_i = 1'b1;
        forever begin
            @(negedge clk);
            if (flit_ready_o) break;
            n++;
            if (n > 500) begin
                fail("send_timeout");
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        flit_valid_i = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || rel_exp) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 3000) fail("drain_timeout");
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_q.delete();
        addr_exp_q.delete();
        in_pkt = 0;
        err_exp = 0;
        rel_exp = 0;
        pkts_exp = 0;
        rel_seen = 0;
        #1;
        chk("rst_ready", 32'(flit_ready_o), 32'd0);
        chk("rst_nhr", 32'(ipc_nhr_write_o), 32'd0);
        chk("rst_req", 32'(ipc_request_o), 32'd0);
        chk("rst_valid", 32'(flit_valid_o), 32'd0);
        chk("rst_release", 32'(ipc_release_o), 32'd0);
        chk("rst_err", 32'(ipc_err_o), 32'd0);
        chk("rst_addr", 32'(ipc_addr_header_o), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", 32'(flit_ready_o), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int len;
        logic [31:0] r;
        logic [1:0] ty;

        do_reset();

        // single-flit packet, exact latency
        ipc_grant_i = 1'b1;
        flit_ready_i = 1'b1;
        flit_i = 32'hC000_0023;
        flit_valid_i = 1'b1;
        @(negedge clk);
        chk("lat_push", 32'(flit_ready_o), 32'd1);
        @(posedge clk);
        #1;
        flit_valid_i = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk("lat_nhr", 32'(ipc_nhr_write_o), 32'(c == 2));
            chk("lat_req", 32'(ipc_request_o), 32'(c == 3));
            chk("lat_valid", 32'(flit_valid_o), 32'(c == 4));
            chk("lat_release", 32'(ipc_release_o), 32'(c == 5));
        end
        @(posedge clk);
        #1;

        // 4-flit packet, grant withheld, FIFO fills
        ipc_grant_i = 1'b0;
        send(32'h4000_0012);
        send(32'h0000_1111);
        send(32'h0000_2222);
        send(32'h8000_3333);
        @(negedge clk);
        chk("full_ready", 32'(flit_ready_o), 32'd0);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("req_held", 32'(ipc_request_o), 32'd1);
            chk("no_valid_wo_grant", 32'(flit_valid_o), 32'd0);
        end
        @(posedge clk);
        #1;
        ipc_grant_i = 1'b1;
        wait_drain();
        chk("release_count_4flit", 32'(rel_seen), 32'(pkts_exp));
        chk("no_err_yet", 32'(ipc_err_o), 32'd0);

        // stray body flit in IDLE
        send(32'h0000_00AA);
        repeat (4) @(posedge clk);
        #1;
        chk("stray_err", 32'(ipc_err_o), 32'(err_exp));
        send(32'hC000_0007);
        wait_drain();
        chk("err_sticky", 32'(ipc_err_o), 32'd1);

        // back-to-back single-flit packets
        send(32'hC000_0011);
        send(32'hC000_0032);
        wait_drain();
        chk("b2b_capture_gap", 32'(last_gap), 32'd1);
        chk("b2b_releases", 32'(rel_seen), 32'(pkts_exp));

        // randomized traffic with random grant/ready
        rnd_mode = 1;
        for (int p = 0; p < 40; p++) begin
            if ($urandom_range(0, 7) == 0)
                send({($urandom_range(0, 1) ? 2'b10 : 2'b00), 30'($urandom)});
            len = $urandom_range(1, 5);
            r = $urandom;
            if (len == 1) begin
                send({2'b11, r[29:0]});
            end else begin
                send({2'b01, r[29:0]});
                for (int b = 1; b < len - 1; b++) begin
                    ty = ($urandom_range(0, 9) == 0) ? 2'b01 : 2'b00;
                    send({ty, 30'($urandom)});
                end
                send({2'b10, 30'($urandom)});
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        wait_drain();
        rnd_mode = 0;
        @(posedge clk);
        #1;
        chk("rnd_releases", 32'(rel_seen), 32'(pkts_exp));
        chk("rnd_err", 32'(ipc_err_o), 32'(err_exp));
        chk("rnd_fifo_empty", 32'(exp_q.size()), 32'd0);

        // reset while forwarding mid-packet
        do_reset();
        ipc_grant_i = 1'b1;
        flit_ready_i = 1'b0;
        send(32'h4000_0055);
        send(32'h0000_5555);
        n = 0;
        while (!flit_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_pkt_forwarding", 32'(flit_valid_o), 32'd1);
        do_reset();
        flit_ready_i = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_valid", 32'(flit_valid_o), 32'd0);
        chk("post_rst_err", 32'(ipc_err_o), 32'd0);
        chk("post_rst_no_release", 32'(rel_seen), 32'd0);
        chk("post_rst_ready", 32'(flit_ready_o), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
